// File: rtl/req_arbiter8_pkg.sv
// Shared types and helpers for the eight-requester arbiter.
// Holds the FSM state encoding, the requester sizing and the bit-manipulation helpers.
package arb_pkg;

  localparam int unsigned NREQ  = 8;
  localparam int unsigned IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;

  // Rotate right by sh: result bit i comes from v[(i + sh) mod NREQ].
  function automatic logic [NREQ-1:0] rotr(input logic [NREQ-1:0]  v,
                                           input logic [IDX_W-1:0] sh);
    logic [NREQ-1:0]  r;
    logic [IDX_W-1:0] j;
    r = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      j    = IDX_W'(i) + sh;
      r[i] = v[j];
    end
    return r;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NREQ-1:0] r;
    r      = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/req_arbiter8_if.sv
// Request/grant bundle between the request sources and the arbiter.
// The master side drives requests and mode; the slave (arbiter) side drives grant status.
interface req_arbiter8_if;
  import arb_pkg::*;

  logic [NREQ-1:0]  req;
  logic             rr_en;
  logic [NREQ-1:0]  gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             busy;
  logic             timeout;

  modport master (
    output req,
    output rr_en,
    input  gnt,
    input  gnt_idx,
    input  busy,
    input  timeout
  );

  modport slave (
    input  req,
    input  rr_en,
    output gnt,
    output gnt_idx,
    output busy,
    output timeout
  );

endinterface

// File: rtl/req_arbiter8_prio_enc8.sv
// Combinational 8-to-3 priority search: index of the highest set bit plus a hit flag.
module prio_enc8
  import arb_pkg::*;
(
  input  logic [NREQ-1:0]  vec,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Ascending scan so the highest set bit is the last one written.
  always_comb begin
    idx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (vec[i]) begin
        idx = IDX_W'(i);
      end
    end
  end

  assign any = |vec;

endmodule

// File: rtl/req_arbiter8.sv
// Eight-requester arbiter: fixed or round-robin priority, grant held until drop or
// hold timeout, with a mandatory one-cycle RELEASE gap between grants.
module req_arbiter8
  import arb_pkg::*;
#(
  parameter  int unsigned HOLD_MAX = 15,
  localparam int unsigned CNT_W    = $clog2(HOLD_MAX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  req_arbiter8_if.slave bus
);

  arb_state_e       state_q, state_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             busy_q, busy_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [IDX_W-1:0] ptr_sel;
  logic [NREQ-1:0]  req_rot;
  logic [IDX_W-1:0] enc_idx;
  logic             enc_any;
  logic [IDX_W-1:0] win_idx;
  logic             held;
  logic             at_limit;

  // Round-robin search: rotate so ptr-1 lands on bit 7, then undo the rotation.
  // A zero rotation reproduces the fixed 7..0 order.
  assign ptr_sel = bus.rr_en ? ptr_q : '0;
  assign req_rot = rotr(bus.req, ptr_sel);

  prio_enc8 u_enc (
    .vec (req_rot),
    .idx (enc_idx),
    .any (enc_any)
  );

  assign win_idx  = enc_idx + ptr_sel;
  assign held     = bus.req[idx_q];
  assign at_limit = (cnt_q == CNT_W'(HOLD_MAX));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      idx_q     <= '0;
      ptr_q     <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      idx_q     <= idx_d;
      ptr_q     <= ptr_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    cnt_d     = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (enc_any) begin
          state_d = GRANT;
          gnt_d   = onehot(win_idx);
          idx_d   = win_idx;
          ptr_d   = win_idx;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end
      end

      GRANT: begin
        // A drop coinciding with the limit is a plain drop: no timeout pulse.
        if (!held) begin
          state_d = RELEASE;
          gnt_d   = '0;
          busy_d  = 1'b0;
        end else if (at_limit) begin
          state_d   = RELEASE;
          gnt_d     = '0;
          busy_d    = 1'b0;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RELEASE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_idx = idx_q;
  assign bus.busy    = busy_q;
  assign bus.timeout = timeout_q;

endmodule
